// File: rtl/huff_line_packer.sv
// Pairs 256-bit shifter words into 512-bit lines, pads the block tail on flush,
// and queues lines in a first-word-fall-through FIFO for the write arbiter.
module huff_line_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         word_valid,
  input  logic [255:0] word_in,
  input  logic         flush,
  input  logic [255:0] tail_data,
  input  logic [8:0]   tail_len,
  output logic [511:0] line_out,
  output logic         line_valid,
  input  logic         line_ready,
  output logic         almost_full,
  output logic [31:0]  total_bits,
  output logic         done,
  output logic         overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_ACCUM, S_TAIL, S_PAD, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [255:0]       hi_q, hi_d;
  logic               half_v_q, half_v_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [7:0]         tail_len_q, tail_len_d;
  logic [255:0]       tail_data_q, tail_data_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic               almost_full_q, almost_full_d;
  logic               overflow_q, overflow_d;
  logic [511:0]       mem_q [FIFO_DEPTH];

  logic [255:0]       tail_word;
  logic [255:0]       acc_data;
  logic               accept;
  logic               push;
  logic [511:0]       push_line;
  logic               pop;
  logic               full;
  logic               push_ok;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_ACCUM;
    else        state_q <= state_d;
  end

  // Next-state logic; TAIL decides on half_v as it stands after the tail word
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACCUM: if (flush) state_d = S_TAIL;
      S_TAIL:  state_d = half_v_d ? S_PAD : S_DONE;
      S_PAD:   state_d = S_DONE;
      S_DONE:  state_d = S_ACCUM;
      default: state_d = S_ACCUM;
    endcase
  end

  // Output logic
  always_comb begin
    done       = (state_q == S_DONE);
    total_bits = (state_q == S_DONE) ? cnt_q : 32'd0;
  end

  // Tail bits are right-aligned; move the oldest bit up to bit 255
  assign tail_word = tail_data_q << (9'd256 - {1'b0, tail_len_q});

  always_comb begin
    accept      = ((state_q == S_ACCUM) && word_valid) ||
                  ((state_q == S_TAIL) && (tail_len_q != 8'd0));
    acc_data    = (state_q == S_TAIL) ? tail_word : word_in;
    hi_d        = hi_q;
    half_v_d    = half_v_q;
    push        = 1'b0;
    push_line   = '0;
    cnt_d       = cnt_q;
    tail_len_d  = tail_len_q;
    tail_data_d = tail_data_q;

    if (accept) begin
      if (!half_v_q) begin
        hi_d     = acc_data;
        half_v_d = 1'b1;
      end else begin
        push      = 1'b1;
        push_line = {hi_q, acc_data};
        half_v_d  = 1'b0;
      end
    end

    case (state_q)
      S_ACCUM: begin
        if (word_valid) cnt_d = cnt_q + 32'd256;
        if (flush) begin
          tail_len_d  = tail_len[8] ? 8'hFF : tail_len[7:0];
          tail_data_d = tail_data;
        end
      end
      S_TAIL: cnt_d = cnt_q + {24'd0, tail_len_q};
      S_PAD: begin
        push      = 1'b1;
        push_line = {hi_q, 256'd0};
        half_v_d  = 1'b0;
      end
      S_DONE:  cnt_d = 32'd0;
      default: cnt_d = cnt_q;
    endcase
  end

  // Line FIFO; a push into a full FIFO is kept only when the head pops this cycle
  always_comb begin
    pop           = (occ_q != '0) && line_ready;
    full          = (occ_q == CNT_W'(FIFO_DEPTH));
    push_ok       = push && (!full || pop);
    wr_ptr_d      = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d         = occ_q;
    if (push_ok && !pop)      occ_d = occ_q + CNT_W'(1);
    else if (!push_ok && pop) occ_d = occ_q - CNT_W'(1);
    overflow_d    = overflow_q | (push && full && !pop);
    almost_full_d = (occ_d >= CNT_W'(FIFO_DEPTH - AF_MARGIN));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q          <= '0;
      half_v_q      <= 1'b0;
      cnt_q         <= '0;
      tail_len_q    <= '0;
      tail_data_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      hi_q          <= hi_d;
      half_v_q      <= half_v_d;
      cnt_q         <= cnt_d;
      tail_len_q    <= tail_len_d;
      tail_data_q   <= tail_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_line;
  end

  assign line_valid  = (occ_q != '0);
  assign line_out    = line_valid ? mem_q[rd_ptr_q] : '0;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/huff_line_packer.md
Name: huff_line_packer

Overview:
- Consumes the 256-bit output words of the 512-bit barrel shifter: its full strobe, its write word, and at end of block its residual bits and residual length.
- Pairs words into 512-bit cache lines, left-aligns and zero-pads the residual tail on flush, and buffers lines in a FIFO for the HARP2 write-request arbiter.
- Reports the total compressed bit count for the block.

Parameters:
- FIFO_DEPTH, 16, line FIFO depth in 512-bit lines (power of 2, at least 4).
- AF_MARGIN, 4, almost_full asserts when occupancy is at least FIFO_DEPTH-AF_MARGIN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low (asserted at 0).
- word_valid  in  1  shifter full strobe; one 256-bit word this cycle.
- word_in  in  256  shifter write word; bit 255 is the oldest bit.
- flush  in  1  end-of-block pulse; valid only in ACCUM.
- tail_data  in  256  residual bits, right-aligned; bit tail_len-1 is the oldest.
- tail_len  in  9  residual bit count, 0..255; sampled with flush.
- line_out  out  512  FIFO head line; line bit 511 is the oldest.
- line_valid  out  1  FIFO not empty.
- line_ready  in  1  consumer accepts the head line when line_valid is also 1.
- almost_full  out  1  upstream must stop feeding the shifter.
- total_bits  out  32  bit count of the last completed block; valid while done is 1.
- done  out  1  one-cycle pulse when flush processing is complete.
- overflow  out  1  sticky error: a line was pushed while the FIFO was full.

Behaviour:
- Reset values: all outputs 0; FSM in ACCUM; half-line register empty; bit counter 0; FIFO empty. Reset asserted mid-block discards all state and FIFO contents.
- Half-line register hi[255:0] with flag half_v.
- word_valid with half_v=0: hi is loaded, half_v set.
- word_valid with half_v=1: line {hi, word_in} is pushed, half_v cleared.
- Each accepted word adds 256 to the 32-bit bit counter; the counter wraps modulo 2^32.
- Latency: a line becomes visible on line_valid in the cycle after its second word is accepted (first-word-fall-through FIFO).
- A simultaneous FIFO push and pop is legal in any state and leaves occupancy unchanged; a push when full is legal only if a pop happens in the same cycle.
- A push when full with no pop drops the line and sets overflow (held until reset).
- FSM states: ACCUM, TAIL, PAD, DONE.
- ACCUM -> TAIL on flush. A word_valid in the same cycle as flush is processed first, as above.
- TAIL, one cycle, only if the sampled tail_len is nonzero: tail word = tail_data << (256 - tail_len), with zeros below. The tail word is treated as an accepted word (pair or load). The bit counter adds tail_len.
- TAIL -> PAD if half_v is 1 after tail handling; otherwise TAIL -> DONE.
- PAD, one cycle: push {hi, 256'd0}, clear half_v.
- PAD -> DONE.
- DONE, one cycle: done=1, total_bits = counter. The counter then resets to 0. DONE -> ACCUM.
- word_valid or flush asserted outside ACCUM is a protocol error; the input is ignored.
- Empty block (no words and tail_len=0): TAIL does nothing, goes to DONE, pushes no line, total_bits=0.
- tail_len is held to 0..255; a value above 255 is a protocol error and is treated as 255.
- almost_full is registered from occupancy. It is the only backpressure, because the shifter cannot stall.
- line_out is held stable while line_valid=1 and line_ready=0.

Test Plan:
- Two words A then B, line_ready=1 -> one line {A,B} on line_valid in the cycle after B; total_bits=512 after a flush with tail_len=0.
- Three words W0..W2, then flush with tail_len=8 and tail_data=8'hA5 -> line {W0,W1}, then line {W2, A5 followed by 248 zeros}; done with total_bits=776.
- One word W0, then flush with tail_len=0 -> PAD line {W0, 256'd0}; total_bits=256.
- Flush with no words and tail_len=0 -> done pulses 2 cycles after flush; no line pushed; total_bits=0.
- line_ready=0, then 2*FIFO_DEPTH+2 words -> almost_full asserts at 12 lines; overflow sets on the 17th line; the first 16 lines drain intact in order once line_ready=1.
- Reset pulled low mid-block with a half line pending and 5 lines queued -> line_valid=0 and overflow=0; the next block's counts start from 0.
